// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side blocks: port-select codes, the
// default backing-RAM base address, the read-tracking payload and a helper
// that maps a select code to its request-vector bit.
package mem_responder_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned NREQ   = 3;

    // Bit positions inside the request / pend / done vectors.
    localparam int unsigned REQ_W = 2;
    localparam int unsigned REQ_D = 1;
    localparam int unsigned REQ_I = 0;

    localparam logic [XLEN-1:0] DEFAULT_BASE_ADDR = 32'h2000_0000;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_W    = 2'd1,
        SEL_D    = 2'd2,
        SEL_I    = 2'd3
    } sel_e;

    // In-flight read: returns one cycle after issue.
    typedef struct packed {
        logic            valid;
        logic            oor;
        logic [XLEN-1:0] addr;
    } rd_track_t;

    // One-hot request bit belonging to a select code (0 for SEL_NONE).
    function automatic logic [NREQ-1:0] sel_bit(input sel_e sel);
        logic [NREQ-1:0] b;
        b = '0;
        case (sel)
            SEL_W:   b[REQ_W] = 1'b1;
            SEL_D:   b[REQ_D] = 1'b1;
            SEL_I:   b[REQ_I] = 1'b1;
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_responder_arb.sv
// mem_arb: combinational fixed-priority selector (W > D > I).
// Ports:
//   pend       - pending request vector {W, D, I}
//   sel        - select code of the request issued this cycle
//   mem_wait_c - more than one request pending, so work remains after this cycle
module mem_arb
    import mem_responder_pkg::*;
(
    input  logic [NREQ-1:0] pend,
    output sel_e            sel,
    output logic            mem_wait_c
);

    always_comb begin
        sel = SEL_NONE;
        if (pend[REQ_W]) begin
            sel = SEL_W;
        end else if (pend[REQ_D]) begin
            sel = SEL_D;
        end else if (pend[REQ_I]) begin
            sel = SEL_I;
        end
        // Clearing the lowest set bit leaves something only if >1 bit was set.
        mem_wait_c = (pend & (pend - NREQ'(1))) != '0;
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: serialises the core's instruction-read, data-read and
// data-write requests onto a single-port backing RAM, one access per cycle.
// Ports:
//   CLK, RST                - clock, async active-low reset
//   INST_RDEN/RIADDR        - instruction read request
//   INST_RVALID/RDATA/ROADDR- instruction read response (1 cycle after issue)
//   DATA_RDEN/RIADDR        - data read request
//   DATA_RVALID/RDATA/ROADDR- data read response (1 cycle after issue)
//   DATA_WREN/WSTRB/WADDR/WDATA - data write request
//   MEM_WAIT                - core must freeze; requests remain after this cycle
//   RAM_EN/WE/ADDR/WDATA    - backing-RAM access
//   RAM_RDATA               - backing-RAM read data, one cycle after a read
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH_LOG2 = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  INST_RDEN,
    input  logic [XLEN-1:0]       INST_RIADDR,
    output logic [XLEN-1:0]       INST_ROADDR,
    output logic                  INST_RVALID,
    output logic [XLEN-1:0]       INST_RDATA,
    input  logic                  DATA_RDEN,
    input  logic [XLEN-1:0]       DATA_RIADDR,
    output logic [XLEN-1:0]       DATA_ROADDR,
    output logic                  DATA_RVALID,
    output logic [XLEN-1:0]       DATA_RDATA,
    input  logic                  DATA_WREN,
    input  logic [STRB_W-1:0]     DATA_WSTRB,
    input  logic [XLEN-1:0]       DATA_WADDR,
    input  logic [XLEN-1:0]       DATA_WDATA,
    output logic                  MEM_WAIT,
    output logic                  RAM_EN,
    output logic [STRB_W-1:0]     RAM_WE,
    output logic [DEPTH_LOG2-1:0] RAM_ADDR,
    output logic [XLEN-1:0]       RAM_WDATA,
    input  logic [XLEN-1:0]       RAM_RDATA
);

    // 33-bit window bounds so the top of the address space cannot wrap.
    localparam logic [XLEN:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [XLEN:0] ADDR_HI = ADDR_LO + ((XLEN+1)'(1) << (DEPTH_LOG2 + 2));

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] done;
    sel_e            sel;
    logic [XLEN-1:0] issue_addr;
    logic [XLEN:0]   issue_addr_ext;
    logic            issue_ok;
    rd_track_t       inst_trk;
    rd_track_t       data_trk;
    logic [XLEN-1:0] inst_hold;
    logic [XLEN-1:0] data_hold;

    assign req[REQ_W] = DATA_WREN;
    assign req[REQ_D] = DATA_RDEN;
    assign req[REQ_I] = INST_RDEN;
    assign pend       = req & ~done;

    mem_arb u_arb (
        .pend       (pend),
        .sel        (sel),
        .mem_wait_c (MEM_WAIT)
    );

    // Issue: address mux, range check, RAM drive (forced idle during reset).
    always_comb begin
        issue_addr = '0;
        case (sel)
            SEL_W:   issue_addr = DATA_WADDR;
            SEL_D:   issue_addr = DATA_RIADDR;
            SEL_I:   issue_addr = INST_RIADDR;
            default: issue_addr = '0;
        endcase
        issue_addr_ext = {1'b0, issue_addr};
        issue_ok = (sel != SEL_NONE) && (issue_addr_ext >= ADDR_LO) &&
                   (issue_addr_ext < ADDR_HI);
        RAM_EN   = RST && issue_ok;
        RAM_WE   = (RST && issue_ok && (sel == SEL_W)) ? DATA_WSTRB : '0;
        RAM_ADDR = issue_ok ? DEPTH_LOG2'((issue_addr - BASE_ADDR) >> 2) : '0;
    end

    assign RAM_WDATA = DATA_WDATA;

    // Responses appear the cycle after issue, straight from RAM_RDATA;
    // the hold registers keep the last returned word between pulses.
    assign INST_RVALID = inst_trk.valid;
    assign INST_ROADDR = inst_trk.addr;
    assign INST_RDATA  = inst_trk.valid ? (inst_trk.oor ? '0 : RAM_RDATA) : inst_hold;
    assign DATA_RVALID = data_trk.valid;
    assign DATA_ROADDR = data_trk.addr;
    assign DATA_RDATA  = data_trk.valid ? (data_trk.oor ? '0 : RAM_RDATA) : data_hold;

    // done tracking and read-return registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            done      <= '0;
            inst_trk  <= '0;
            data_trk  <= '0;
            inst_hold <= '0;
            data_hold <= '0;
        end else begin
            done <= MEM_WAIT ? (done | sel_bit(sel)) : '0;

            inst_trk.valid <= (sel == SEL_I);
            data_trk.valid <= (sel == SEL_D);
            if (sel == SEL_I) begin
                inst_trk.oor  <= !issue_ok;
                inst_trk.addr <= INST_RIADDR;
            end
            if (sel == SEL_D) begin
                data_trk.oor  <= !issue_ok;
                data_trk.addr <= DATA_RIADDR;
            end
            if (inst_trk.valid) begin
                inst_hold <= INST_RDATA;
            end
            if (data_trk.valid) begin
                data_hold <= DATA_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a behavioural single-port RAM.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned DL = 14;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          INST_RDEN = 1'b0;
    logic [31:0]   INST_RIADDR = '0;
    logic [31:0]   INST_ROADDR;
    logic          INST_RVALID;
    logic [31:0]   INST_RDATA;
    logic          DATA_RDEN = 1'b0;
    logic [31:0]   DATA_RIADDR = '0;
    logic [31:0]   DATA_ROADDR;
    logic          DATA_RVALID;
    logic [31:0]   DATA_RDATA;
    logic          DATA_WREN = 1'b0;
    logic [3:0]    DATA_WSTRB = '0;
    logic [31:0]   DATA_WADDR = '0;
    logic [31:0]   DATA_WDATA = '0;
    logic          MEM_WAIT;
    logic          RAM_EN;
    logic [3:0]    RAM_WE;
    logic [DL-1:0] RAM_ADDR;
    logic [31:0]   RAM_WDATA;
    logic [31:0]   RAM_RDATA;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    logic [31:0] mem [0:(1<<DL)-1];
    logic [31:0] exp6 [0:7];

    mem_responder #(.BASE_ADDR(32'h2000_0000), .DEPTH_LOG2(DL)) dut (
        .CLK(CLK), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_ROADDR(INST_ROADDR),
        .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
        .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
        .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
        .DATA_WREN(DATA_WREN), .DATA_WSTRB(DATA_WSTRB), .DATA_WADDR(DATA_WADDR),
        .DATA_WDATA(DATA_WDATA), .MEM_WAIT(MEM_WAIT),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM: byte-enabled write, registered read.
    initial begin
        logic [31:0] w;
        for (int i = 0; i < (1 << DL); i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_2222;
        mem[1] = 32'h0BAD_F00D;
        mem[2] = 32'hCAFE_0002;
        mem[3] = 32'h5000_0003;
        mem[4] = 32'hDEAD_BEEF;
        mem[5] = 32'h5000_0005;
        mem[6] = 32'h5000_0006;
        mem[7] = 32'h5000_0007;
        RAM_RDATA = 32'h0;
        forever begin
            @(posedge CLK);
            if (RAM_EN) begin
                if (RAM_WE == 4'b0000) begin
                    RAM_RDATA <= mem[RAM_ADDR];
                end else begin
                    w = mem[RAM_ADDR];
                    for (int b = 0; b < 4; b++)
                        if (RAM_WE[b]) w[8*b +: 8] = RAM_WDATA[8*b +: 8];
                    mem[RAM_ADDR] <= w;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, where inputs are driven.
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        INST_RDEN = 1'b0;
        DATA_RDEN = 1'b0;
        DATA_WREN = 1'b0;
        DATA_WSTRB = 4'b0000;
    endtask

    initial begin
        exp6[0] = 32'h1111_5678; exp6[1] = 32'h0BAD_F00D;
        exp6[2] = 32'hCAFE_0002; exp6[3] = 32'h5000_0003;
        exp6[4] = 32'hDEAD_BEEF; exp6[5] = 32'h5000_0005;
        exp6[6] = 32'h5000_0006; exp6[7] = 32'h5000_0007;

        // Reset state, with requests asserted to show RAM drive is gated.
        INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0010;
        DATA_WREN = 1'b1; DATA_WSTRB = 4'b1111; DATA_WADDR = 32'h2000_0000;
        @(negedge CLK); @(negedge CLK); #1;
        chk("rst_ram_en", RAM_EN, 1'b0);
        chk("rst_ram_we", RAM_WE, 4'b0000);
        chk("rst_inst_rvalid", INST_RVALID, 1'b0);
        chk("rst_data_rvalid", DATA_RVALID, 1'b0);
        chk("rst_inst_roaddr", INST_ROADDR, 32'h0);
        chk("rst_data_roaddr", DATA_ROADDR, 32'h0);
        chk("rst_inst_rdata", INST_RDATA, 32'h0);
        chk("rst_data_rdata", DATA_RDATA, 32'h0);
        idle_inputs();

        // Lone instruction read, issued on the first edge after release.
        @(negedge CLK);
        RST = 1'b1;
        INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0010;
        #1;
        chk("s1_ram_en", RAM_EN, 1'b1);
        chk("s1_ram_addr", 32'(RAM_ADDR), 32'd4);
        chk("s1_ram_we", RAM_WE, 4'b0000);
        chk("s1_wait0", MEM_WAIT, 1'b0);
        cyc(); idle_inputs(); #1;
        chk("s1_rvalid", INST_RVALID, 1'b1);
        chk("s1_rdata", INST_RDATA, 32'hDEAD_BEEF);
        chk("s1_roaddr", INST_ROADDR, 32'h2000_0010);
        chk("s1_wait1", MEM_WAIT, 1'b0);
        cyc(); #1;
        chk("s1_rvalid_drop", INST_RVALID, 1'b0);
        chk("s1_rdata_hold", INST_RDATA, 32'hDEAD_BEEF);

        // W, D and I together.
        DATA_WREN = 1'b1; DATA_WSTRB = 4'b0011; DATA_WADDR = 32'h2000_0000;
        DATA_WDATA = 32'h1234_5678;
        DATA_RDEN = 1'b1; DATA_RIADDR = 32'h2000_0004;
        INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0008;
        #1;
        chk("s2_c0_wait", MEM_WAIT, 1'b1);
        chk("s2_c0_we", RAM_WE, 4'b0011);
        chk("s2_c0_addr", 32'(RAM_ADDR), 32'd0);
        cyc(); #1;
        chk("s2_c1_wait", MEM_WAIT, 1'b1);
        chk("s2_c1_en", RAM_EN, 1'b1);
        chk("s2_c1_we", RAM_WE, 4'b0000);
        chk("s2_c1_addr", 32'(RAM_ADDR), 32'd1);
        chk("s2_c1_drvalid", DATA_RVALID, 1'b0);
        cyc(); #1;
        chk("s2_c2_wait", MEM_WAIT, 1'b0);
        chk("s2_c2_addr", 32'(RAM_ADDR), 32'd2);
        chk("s2_c2_drvalid", DATA_RVALID, 1'b1);
        chk("s2_c2_drdata", DATA_RDATA, 32'h0BAD_F00D);
        chk("s2_c2_droaddr", DATA_ROADDR, 32'h2000_0004);
        chk("s2_c2_irvalid", INST_RVALID, 1'b0);
        cyc(); idle_inputs(); #1;
        chk("s2_c3_irvalid", INST_RVALID, 1'b1);
        chk("s2_c3_irdata", INST_RDATA, 32'hCAFE_0002);
        chk("s2_c3_iroaddr", INST_ROADDR, 32'h2000_0008);
        chk("s2_c3_drvalid", DATA_RVALID, 1'b0);
        chk("s2_c3_en", RAM_EN, 1'b0);
        chk("s2_word0", mem[0], 32'h1111_5678);

        // Write then read the same word.
        DATA_WREN = 1'b1; DATA_WSTRB = 4'b1111; DATA_WADDR = 32'h2000_0020;
        DATA_WDATA = 32'hAABB_CCDD;
        cyc(); idle_inputs();
        DATA_RDEN = 1'b1; DATA_RIADDR = 32'h2000_0020; #1;
        chk("s3_addr", 32'(RAM_ADDR), 32'd8);
        chk("s3_wait", MEM_WAIT, 1'b0);
        cyc(); idle_inputs(); #1;
        chk("s3_rvalid", DATA_RVALID, 1'b1);
        chk("s3_rdata", DATA_RDATA, 32'hAABB_CCDD);

        // Out-of-range reads below and above the window, last in-range word, OOR write.
        DATA_RDEN = 1'b1; DATA_RIADDR = 32'h1FFF_FFFC; #1;
        chk("s4_lo_en", RAM_EN, 1'b0);
        cyc(); DATA_RIADDR = 32'h2001_0000; #1;
        chk("s4_lo_rvalid", DATA_RVALID, 1'b1);
        chk("s4_lo_rdata", DATA_RDATA, 32'h0);
        chk("s4_lo_roaddr", DATA_ROADDR, 32'h1FFF_FFFC);
        chk("s4_hi_en", RAM_EN, 1'b0);
        cyc(); DATA_RIADDR = 32'h2000_FFFC; #1;
        chk("s4_hi_rvalid", DATA_RVALID, 1'b1);
        chk("s4_hi_rdata", DATA_RDATA, 32'h0);
        chk("s4_hi_roaddr", DATA_ROADDR, 32'h2001_0000);
        chk("s4_top_en", RAM_EN, 1'b1);
        chk("s4_top_addr", 32'(RAM_ADDR), 32'h0000_3FFF);
        cyc(); idle_inputs();
        DATA_WREN = 1'b1; DATA_WSTRB = 4'b1111; DATA_WADDR = 32'h2001_0000; #1;
        chk("s4_wr_en", RAM_EN, 1'b0);
        chk("s4_wr_we", RAM_WE, 4'b0000);
        chk("s4_wr_wait", MEM_WAIT, 1'b0);
        cyc(); idle_inputs();

        // Reset right after a D issue while I is still pending.
        DATA_RDEN = 1'b1; DATA_RIADDR = 32'h2000_0004;
        INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0008; #1;
        chk("s5_wait", MEM_WAIT, 1'b1);
        @(posedge CLK); #2;
        RST = 1'b0; #1;
        chk("s5_async_en", RAM_EN, 1'b0);
        chk("s5_rst_drvalid", DATA_RVALID, 1'b0);
        @(negedge CLK); idle_inputs();
        @(negedge CLK); RST = 1'b1; #1;
        chk("s5_rel_drvalid", DATA_RVALID, 1'b0);
        chk("s5_rel_irvalid", INST_RVALID, 1'b0);
        cyc(); #1;
        chk("s5_rel2_drvalid", DATA_RVALID, 1'b0);
        DATA_RDEN = 1'b1; DATA_RIADDR = 32'h2000_0004;
        INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0008; #1;
        chk("s5_done_clear_wait", MEM_WAIT, 1'b1);
        chk("s5_done_clear_addr", 32'(RAM_ADDR), 32'd1);
        cyc(); #1;
        chk("s5_d_rvalid", DATA_RVALID, 1'b1);
        chk("s5_d_rdata", DATA_RDATA, 32'h0BAD_F00D);
        cyc(); idle_inputs(); #1;
        chk("s5_i_rvalid", INST_RVALID, 1'b1);
        chk("s5_i_rdata", INST_RDATA, 32'hCAFE_0002);

        // Eight back-to-back lone instruction reads.
        for (int i = 0; i < 8; i++) begin
            INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0000 + 32'(4 * i); #1;
            chk($sformatf("s6_wait_%0d", i), MEM_WAIT, 1'b0);
            if (i > 0) begin
                chk($sformatf("s6_rvalid_%0d", i - 1), INST_RVALID, 1'b1);
                chk($sformatf("s6_rdata_%0d", i - 1), INST_RDATA, exp6[i-1]);
                chk($sformatf("s6_roaddr_%0d", i - 1), INST_ROADDR,
                    32'h2000_0000 + 32'(4 * (i - 1)));
            end
            cyc();
        end
        idle_inputs(); #1;
        chk("s6_rvalid_7", INST_RVALID, 1'b1);
        chk("s6_rdata_7", INST_RDATA, exp6[7]);
        chk("s6_roaddr_7", INST_ROADDR, 32'h2000_001C);
        chk("s6_wait_end", MEM_WAIT, 1'b0);
        cyc(); #1;
        chk("s6_rvalid_end", INST_RVALID, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
